data_memory_ctrl: RTL and testbench

Parametrised data memory for the ARM core's MEM stage, generalising the fixed 64-word, base-1024 data RAM. Adds:
- configurable width, depth and base address
- byte-enable writes
- a valid/ready request/response handshake with programmable wait states
- address error detection
- an automatic post-reset clear sweep

One outstanding transaction at a time.

---
 rtl/data_memory_pkg.sv | 21 ++
 rtl/data_memory_decode.sv | 28 ++
 rtl/data_memory_ctrl.sv | 124 ++++++++++++
 tb/tb_data_memory_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared types and helpers for the data memory controller
package data_memory_pkg;

    typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

    localparam int MAX_W = 512;
    localparam int MAX_B = MAX_W / 8;

    // Byte-lane merge at the widest supported word; callers extend and truncate
    function automatic logic [MAX_W-1:0] be_merge(
        input logic [MAX_W-1:0] old_w,
        input logic [MAX_W-1:0] new_w,
        input logic [MAX_B-1:0] be
    );
        logic [MAX_W-1:0] res;
        for (int k = 0; k < MAX_B; k++)
            res[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
        return res;
    endfunction

endpackage

// File: rtl/data_memory_decode.sv
// data_memory_decode: byte address to word index with range and alignment check
module data_memory_decode
    import data_memory_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 1024,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  idx,
    output logic              err
);

    localparam int OFF_W = $clog2(DATA_W / 8);

    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] word;

    assign off  = addr - BASE_ADDR;
    assign word = off >> OFF_W;
    assign idx  = word[IDX_W-1:0];
    // Below base, misaligned or past the last word: never alias
    assign err  = (addr < BASE_ADDR) || ((off & ADDR_W'(DATA_W / 8 - 1)) != '0) ||
                  (word >= ADDR_W'(DEPTH));

endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: handshaked byte-enable data RAM with wait states and clear sweep
module data_memory_ctrl
    import data_memory_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH = 64,
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 1024,
    parameter int WAIT_CYCLES = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);

    state_t            state;
    logic [IDX_W-1:0]  clr_cnt;
    logic [IDX_W-1:0]  d_idx;
    logic [IDX_W-1:0]  l_idx;
    logic              d_err;
    logic              l_err;
    logic              l_write;
    logic [DATA_W-1:0] l_wdata;
    logic [BYTES-1:0]  l_be;
    logic [3:0]        wcnt;
    logic [DATA_W-1:0] mem [DEPTH];

    data_memory_decode #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH(DEPTH),
        .BASE_ADDR(BASE_ADDR)
    ) u_decode (
        .addr(req_addr),
        .idx(d_idx),
        .err(d_err)
    );

    // Control FSM; RESP with rsp_valid low is the single access cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= (CLEAR_ON_RESET != 0) ? INIT : IDLE;
            busy      <= (CLEAR_ON_RESET != 0);
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            clr_cnt   <= '0;
            wcnt      <= '0;
            l_idx     <= '0;
            l_err     <= 1'b0;
            l_write   <= 1'b0;
            l_wdata   <= '0;
            l_be      <= '0;
        end else begin
            case (state)
                INIT: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == IDX_W'(DEPTH - 1)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (req_valid && req_ready) begin
                        l_write   <= req_write;
                        l_wdata   <= req_wdata;
                        l_be      <= req_be;
                        l_idx     <= d_idx;
                        l_err     <= d_err;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        wcnt      <= 4'(WAIT_CYCLES - 1);
                        state     <= (WAIT_CYCLES > 0) ? WAIT : RESP;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    wcnt <= wcnt - 1'b1;
                    if (wcnt == '0)
                        state <= RESP;
                end
                RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= l_err;
                        rsp_rdata <= (l_write || l_err) ? '0 : mem[l_idx];
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage: zero sweep during INIT, byte-merged write on the access cycle
    always_ff @(posedge clk) begin
        if (state == INIT)
            mem[clr_cnt] <= '0;
        else if (state == RESP && !rsp_valid && l_write && !l_err)
            mem[l_idx] <= DATA_W'(be_merge(MAX_W'(mem[l_idx]), MAX_W'(l_wdata), MAX_B'(l_be)));
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: scoreboard bench for default and 64-bit zero-wait configurations
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_be = '0;
    logic        rsp_ready = 1'b1;
    logic        sel_b = 1'b0;

    logic        a_req_ready, a_rsp_valid, a_rsp_err, a_busy;
    logic [31:0] a_rsp_rdata;
    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_busy;
    logic [63:0] b_rsp_rdata;

    logic        o_req_ready, o_rsp_valid, o_err;
    logic [63:0] o_rdata;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    data_memory_ctrl u_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(a_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_be(req_be[3:0]),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err), .busy(a_busy)
    );

    data_memory_ctrl #(.DATA_W(64), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(b_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .busy(b_busy)
    );

    assign o_req_ready = sel_b ? b_req_ready : a_req_ready;
    assign o_rsp_valid = sel_b ? b_rsp_valid : a_rsp_valid;
    assign o_err       = sel_b ? b_rsp_err : a_rsp_err;
    assign o_rdata     = sel_b ? b_rsp_rdata : {32'h0, a_rsp_rdata};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_init();
        int   n = 0;
        logic bad = 1'b0;
        while (a_busy && n < 200) begin
            bad |= a_req_ready;
            @(negedge clk);
            n++;
        end
        check("init_cycles", 64'(n), 64'd64);
        check("init_ready_low", {63'h0, bad}, 64'h0);
    endtask

    task automatic txn(input logic w, input logic [31:0] addr, input logic [63:0] wd,
                       input logic [7:0] be, input logic [63:0] er, input logic ee,
                       input int hold);
        exp_t e;
        int   t = 0;
        int   lat = 0;
        exp_q.push_back('{er, ee});
        @(negedge clk);
        rsp_ready = (hold == 0);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        while (!o_req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("accept", {63'h0, t < 200}, 64'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        while (!o_rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), sel_b ? 64'd1 : 64'd2);
        e = exp_q.pop_front();
        check("rdata", o_rdata, e.rdata);
        check("err", {63'h0, o_err}, {63'h0, e.err});
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("bp_valid", {63'h0, o_rsp_valid}, 64'h1);
                check("bp_rdata", o_rdata, e.rdata);
                check("bp_req_ready", {63'h0, o_req_ready}, 64'h0);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            check("release_valid", {63'h0, o_rsp_valid}, 64'h0);
            check("release_req_ready", {63'h0, o_req_ready}, 64'h1);
        end
    endtask

    initial begin
        int   t;
        logic seen;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {63'h0, a_req_ready}, 64'h0);
        check("rst_rsp_valid", {63'h0, a_rsp_valid}, 64'h0);
        check("rst_rdata", {32'h0, a_rsp_rdata}, 64'h0);
        check("rst_err", {63'h0, a_rsp_err}, 64'h0);
        check("rst_busy", {63'h0, a_busy}, 64'h1);
        rst = 1'b1;
        wait_init();

        sel_b = 1'b0;
        txn(0, 32'h400, 0, 8'hF, 64'h0, 0, 0);
        txn(1, 32'h4FC, 64'hDEADBEEF, 8'hF, 64'h0, 0, 0);
        txn(0, 32'h4FC, 0, 8'hF, 64'hDEADBEEF, 0, 0);
        txn(1, 32'h404, 64'hDEADBEEF, 8'hF, 64'h0, 0, 0);
        txn(1, 32'h404, 64'h11223344, 8'h5, 64'h0, 0, 0);
        txn(0, 32'h404, 0, 8'h0, 64'hDE22BE44, 0, 0);
        txn(0, 32'h3FC, 0, 8'hF, 64'h0, 1, 0);
        txn(0, 32'h500, 0, 8'hF, 64'h0, 1, 0);
        txn(1, 32'h402, 64'hFFFFFFFF, 8'hF, 64'h0, 1, 0);
        txn(0, 32'h400, 0, 8'hF, 64'h0, 0, 0);
        txn(0, 32'h404, 0, 8'hF, 64'hDE22BE44, 0, 0);
        txn(1, 32'h404, 64'hFFFFFFFF, 8'h0, 64'h0, 0, 0);
        txn(0, 32'h404, 0, 8'hF, 64'hDE22BE44, 0, 0);
        txn(0, 32'h4FC, 0, 8'h0, 64'hDEADBEEF, 0, 5);
        txn(1, 32'h408, 64'hCAFEF00D, 8'hF, 64'h0, 0, 0);
        txn(0, 32'h408, 0, 8'hF, 64'hCAFEF00D, 0, 0);

        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h408;
        req_wdata = 64'h12345678;
        req_be    = 8'hF;
        t = 0;
        while (!a_req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("midop_accept", {63'h0, t < 200}, 64'h1);
        @(posedge clk);
        #1 rst = 1'b0;
        req_valid = 1'b0;
        #1;
        check("midop_req_ready", {63'h0, a_req_ready}, 64'h0);
        check("midop_rsp_valid", {63'h0, a_rsp_valid}, 64'h0);
        check("midop_rdata", {32'h0, a_rsp_rdata}, 64'h0);
        check("midop_err", {63'h0, a_rsp_err}, 64'h0);
        check("midop_busy", {63'h0, a_busy}, 64'h1);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen |= a_rsp_valid;
        end
        check("midop_no_rsp", {63'h0, seen}, 64'h0);
        rst = 1'b1;
        wait_init();
        txn(0, 32'h408, 0, 8'hF, 64'h0, 0, 0);

        sel_b = 1'b1;
        txn(1, 32'h8, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 0, 0);
        txn(0, 32'h8, 0, 8'hFF, 64'h0123456789ABCDEF, 0, 0);
        txn(1, 32'h10, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 64'h0, 0, 0);
        txn(0, 32'h10, 0, 8'hFF, 64'h00000000FFFFFFFF, 0, 0);
        txn(0, 32'h4, 0, 8'hFF, 64'h0, 1, 0);
        txn(0, 32'h1F8, 0, 8'hFF, 64'h0, 0, 0);
        txn(0, 32'h200, 0, 8'hFF, 64'h0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
